// File: rtl/bus_sram_responder.sv
// Bus-side SRAM responder for the V68k asynchronous bus.
// Captures a bus cycle on AS low, inserts WAIT_STATES wait cycles, then acknowledges
// with DTACK (hit) or raises BERR (address outside the decoded window).
module bus_sram_responder #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter logic [23:0] BASE        = 24'h000000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [23:1] A,
  input  logic        AS,
  input  logic        UDS,
  input  logic        LDS,
  input  logic        RW,
  inout  wire  [15:0] D,
  output logic        DTACK,
  output logic        BERR
);

  localparam int unsigned Words    = 2 ** ADDR_BITS;
  localparam logic [3:0]  WaitLoad = 4'(WAIT_STATES);

  typedef enum logic [1:0] {StIdle, StWait, StAck, StErr} state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 berr_q, berr_d;
  logic [ADDR_BITS-1:0] idx_q;
  logic                 uds_q, lds_q, rw_q;
  logic [15:0]          rdata_q;
  logic                 capture;
  logic                 ack_start;
  logic                 hit;
  logic                 mem_we;
  logic [23:0]          byte_addr;
  logic [15:0]          mem [Words];

  // Window decode: every address bit above the SRAM span must match BASE.
  assign byte_addr = {A, 1'b0};
  assign hit       = ((byte_addr ^ BASE) >> (ADDR_BITS + 1)) == 24'd0;

  // Next-state logic for the bus cycle sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    berr_d    = berr_q;
    capture   = 1'b0;
    ack_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!AS) begin
          capture = 1'b1;
          if (hit) begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end else begin
            state_d = StErr;
          end
        end
      end
      StWait: begin
        if (AS) begin
          // CPU abandoned the cycle before acknowledge: no access at all.
          state_d = StIdle;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d   = StAck;
          ack_start = 1'b1;
        end
      end
      StAck: begin
        if (AS) begin
          state_d = StIdle;
        end
      end
      StErr: begin
        if (AS) begin
          state_d = StIdle;
          berr_d  = 1'b0;
        end else begin
          berr_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The single SRAM write happens on the edge that enters ACK, never again while ACK holds.
  assign mem_we = ack_start & ~rw_q;

  // Sequencer state, wait counter and captured cycle attributes.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      berr_q  <= 1'b0;
      idx_q   <= '0;
      uds_q   <= 1'b1;
      lds_q   <= 1'b1;
      rw_q    <= 1'b1;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      berr_q  <= berr_d;
      if (capture) begin
        idx_q <= A[ADDR_BITS:1];
        uds_q <= UDS;
        lds_q <= LDS;
        rw_q  <= RW;
      end
      if (ack_start) begin
        rdata_q <= mem[idx_q];
      end
    end
  end

  // SRAM array: byte-lane writes, contents survive reset.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      if (!uds_q) begin
        mem[idx_q][15:8] <= D[15:8];
      end
      if (!lds_q) begin
        mem[idx_q][7:0] <= D[7:0];
      end
    end
  end

  // Outputs follow state directly so reset releases them without waiting for a clock.
  assign DTACK = (state_q == StAck);
  assign BERR  = berr_q;
  assign D     = (state_q == StAck && rw_q) ? rdata_q : 16'hzzzz;

endmodule

// File: tb/tb_bus_sram_responder.sv
// Self-checking bench: three responders with 1, 3 and 0 wait states, directed cycles
// followed by randomized traffic checked against a word-array memory model.
module tb_bus_sram_responder;

  logic        clk;
  logic        rst;
  logic [23:1] a;
  logic        uds, lds, rw;
  logic        as_n [3];
  logic [15:0] dv   [3];
  logic        de   [3];
  wire  [15:0] d0, d1, d2;
  wire         dt0, dt1, dt2;
  wire         be0, be1, be2;

  int errors = 0;
  int checks = 0;

  // Reference memory for the randomized phase (word index -> contents).
  logic [15:0] model [1024];

  assign d0 = de[0] ? dv[0] : 16'hzzzz;
  assign d1 = de[1] ? dv[1] : 16'hzzzz;
  assign d2 = de[2] ? dv[2] : 16'hzzzz;

  bus_sram_responder #(.ADDR_BITS(10), .BASE(24'h000000), .WAIT_STATES(1)) u0 (
    .CLK(clk), .RESET(rst), .A(a), .AS(as_n[0]), .UDS(uds), .LDS(lds), .RW(rw),
    .D(d0), .DTACK(dt0), .BERR(be0)
  );
  bus_sram_responder #(.ADDR_BITS(10), .BASE(24'h000000), .WAIT_STATES(3)) u1 (
    .CLK(clk), .RESET(rst), .A(a), .AS(as_n[1]), .UDS(uds), .LDS(lds), .RW(rw),
    .D(d1), .DTACK(dt1), .BERR(be1)
  );
  bus_sram_responder #(.ADDR_BITS(10), .BASE(24'h000000), .WAIT_STATES(0)) u2 (
    .CLK(clk), .RESET(rst), .A(a), .AS(as_n[2]), .UDS(uds), .LDS(lds), .RW(rw),
    .D(d2), .DTACK(dt2), .BERR(be2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] bus_d(input int u);
    case (u)
      0:       return d0;
      1:       return d1;
      default: return d2;
    endcase
  endfunction

  function automatic logic dtack_of(input int u);
    case (u)
      0:       return dt0;
      1:       return dt1;
      default: return dt2;
    endcase
  endfunction

  function automatic logic berr_of(input int u);
    case (u)
      0:       return be0;
      1:       return be1;
      default: return be2;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete bus cycle on instance u. lat = edges after the capture edge until
  // DTACK/BERR (-1 on timeout); rdata = D seen at acknowledge.
  task automatic cycle(input int u, input logic [23:1] addr, input logic rw_i,
                       input logic uds_i, input logic lds_i, input logic [15:0] wdata,
                       input int hold, input bit scramble,
                       output logic [15:0] rdata, output int lat, output bit got_berr);
    @(negedge clk);
    a    = addr;
    rw   = rw_i;
    uds  = uds_i;
    lds  = lds_i;
    de[u] = !rw_i;
    dv[u] = wdata;
    as_n[u] = 1'b0;
    lat = -1;
    got_berr = 1'b0;
    rdata = 16'h0000;
    for (int k = 0; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 0 && scramble) begin
        a   = 23'($urandom);
        uds = 1'($urandom);
        lds = 1'($urandom);
        rw  = 1'($urandom);
      end
      if (dtack_of(u) || berr_of(u)) begin
        lat = k;
        got_berr = berr_of(u);
        break;
      end
    end
    check("exclusive", {31'd0, dtack_of(u) & berr_of(u)}, 32'd0);
    if (got_berr) begin
      check("err_dtack", {31'd0, dtack_of(u)}, 32'd0);
      de[u] = 1'b1;
      dv[u] = 16'h0000;
      #1;
      check("err_d_released", {16'd0, bus_d(u)}, 32'd0);
    end else if (lat >= 0) begin
      rdata = bus_d(u);
      for (int h = 0; h < hold; h++) begin
        if (!rw_i) dv[u] = ~wdata;
        @(posedge clk);
        #1;
        check("ack_held", {31'd0, dtack_of(u)}, 32'd1);
      end
    end
    @(negedge clk);
    as_n[u] = 1'b1;
    @(posedge clk);
    #1;
    check("end_dtack", {31'd0, dtack_of(u)}, 32'd0);
    check("end_berr", {31'd0, berr_of(u)}, 32'd0);
    de[u] = 1'b1;
    dv[u] = 16'h0000;
    #1;
    check("end_d_released", {16'd0, bus_d(u)}, 32'd0);
    de[u] = 1'b0;
  endtask

  // Hit write with expected latency, plus check that D carried the bench's data.
  task automatic do_write(input int u, input logic [23:1] addr, input logic uds_i,
                          input logic lds_i, input logic [15:0] wdata, input int exp_lat,
                          input int hold, input bit scramble);
    logic [15:0] rd;
    int          lat;
    bit          be;
    cycle(u, addr, 1'b0, uds_i, lds_i, wdata, hold, scramble, rd, lat, be);
    check("wr_lat", lat, exp_lat);
    check("wr_berr", {31'd0, be}, 32'd0);
    check("wr_d_not_driven", {16'd0, rd}, {16'd0, wdata});
  endtask

  task automatic do_read(input int u, input logic [23:1] addr, input logic [15:0] exp_d,
                         input int exp_lat, input bit scramble);
    logic [15:0] rd;
    int          lat;
    bit          be;
    cycle(u, addr, 1'b1, 1'b0, 1'b0, 16'h0000, 0, scramble, rd, lat, be);
    check("rd_lat", lat, exp_lat);
    check("rd_berr", {31'd0, be}, 32'd0);
    check("rd_data", {16'd0, rd}, {16'd0, exp_d});
  endtask

  task automatic do_miss(input int u, input logic [23:1] addr, input logic rw_i);
    logic [15:0] rd;
    int          lat;
    bit          be;
    cycle(u, addr, rw_i, 1'b0, 1'b0, 16'h0000, 0, 1'b0, rd, lat, be);
    check("miss_lat", lat, 1);
    check("miss_berr", {31'd0, be}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [22:0] upper;
    logic [23:1] ad;
    logic [15:0] wd, nw;
    int          idx, op;
    int          seen;
    bit          u_n, l_n;

    rst = 1'b1;
    a = '0;
    uds = 1'b1;
    lds = 1'b1;
    rw = 1'b1;
    for (int u = 0; u < 3; u++) begin
      as_n[u] = 1'b1;
      de[u] = 1'b1;
      dv[u] = 16'h0000;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      check("rst_dtack", {31'd0, dtack_of(u)}, 32'd0);
      check("rst_berr", {31'd0, berr_of(u)}, 32'd0);
      check("rst_d_released", {16'd0, bus_d(u)}, 32'd0);
      de[u] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;

    // One wait state: write, read-back, byte lanes, null cycle.
    do_write(0, 23'h000010, 1'b0, 1'b0, 16'hBEEF, 2, 0, 1'b0);
    do_read(0, 23'h000010, 16'hBEEF, 2, 1'b0);
    do_write(0, 23'h000010, 1'b0, 1'b1, 16'h1234, 2, 0, 1'b0);
    do_read(0, 23'h000010, 16'h12EF, 2, 1'b0);
    do_write(0, 23'h000010, 1'b1, 1'b0, 16'hAA55, 2, 0, 1'b0);
    do_read(0, 23'h000010, 16'h1255, 2, 1'b0);
    do_write(0, 23'h000010, 1'b1, 1'b1, 16'hFFFF, 2, 0, 1'b0);
    do_read(0, 23'h000010, 16'h1255, 2, 1'b0);

    // Misses, including one aliasing index 0x10; memory must be untouched.
    do_miss(0, 23'h400000, 1'b1);
    do_miss(0, 23'h400010, 1'b0);
    do_read(0, 23'h000010, 16'h1255, 2, 1'b0);

    // Long ACK with D changing underneath: only the first-edge data is stored.
    do_write(0, 23'h000020, 1'b0, 1'b0, 16'hCAFE, 2, 3, 1'b0);
    do_read(0, 23'h000020, 16'hCAFE, 2, 1'b0);
    // Pins scrambled after capture must not affect the cycle.
    do_write(0, 23'h000021, 1'b0, 1'b0, 16'h5A5A, 2, 0, 1'b1);
    do_read(0, 23'h000021, 16'h5A5A, 2, 1'b1);

    // Three wait states: abort during WAIT.
    do_write(1, 23'h000005, 1'b0, 1'b0, 16'h1111, 4, 0, 1'b0);
    @(negedge clk);
    a = 23'h000005;
    rw = 1'b0;
    uds = 1'b0;
    lds = 1'b0;
    de[1] = 1'b1;
    dv[1] = 16'h2222;
    as_n[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_wait_dtack", {31'd0, dt1}, 32'd0);
    @(negedge clk);
    as_n[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check("abort_no_dtack", {30'd0, dt1, be1}, 32'd0);
    end
    de[1] = 1'b0;
    do_read(1, 23'h000005, 16'h1111, 4, 1'b0);

    // Asynchronous reset in the middle of a read acknowledge.
    @(negedge clk);
    a = 23'h000005;
    rw = 1'b1;
    de[1] = 1'b0;
    as_n[1] = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(posedge clk);
      #1;
      if (dt1) seen = 1;
    end
    check("rst_mid_ack_reached", seen, 1);
    check("rst_mid_ack_data", {16'd0, d1}, 32'h1111);
    #2;
    rst = 1'b1;
    de[1] = 1'b1;
    dv[1] = 16'h0000;
    #1;
    check("async_rst_dtack", {31'd0, dt1}, 32'd0);
    check("async_rst_d", {16'd0, d1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    as_n[1] = 1'b1;
    de[1] = 1'b0;
    do_read(1, 23'h000005, 16'h1111, 4, 1'b0);

    // Zero wait states, back-to-back reads including the NOP opcode.
    do_write(2, 23'h000100, 1'b0, 1'b0, 16'h4E71, 1, 0, 1'b0);
    do_write(2, 23'h000101, 1'b0, 1'b0, 16'h1234, 1, 0, 1'b0);
    do_read(2, 23'h000100, 16'h4E71, 1, 1'b0);
    do_read(2, 23'h000101, 16'h1234, 1, 1'b0);
    do_read(2, 23'h000100, 16'h4E71, 1, 1'b0);

    // Randomized traffic on the one-wait-state responder against the model.
    for (int i = 0; i < 16; i++) begin
      wd = 16'($urandom);
      model[16'h40 + i] = wd;
      do_write(0, 23'(16'h40 + i), 1'b0, 1'b0, wd, 2, 0, 1'b0);
    end
    for (int i = 0; i < 60; i++) begin
      idx = 16'h40 + $urandom_range(15);
      op  = $urandom_range(7);
      if (op == 0) begin
        upper = 23'($urandom_range(8191, 1));
        ad    = 23'((upper << 10) | 23'(idx));
        do_miss(0, ad, 1'($urandom));
      end else if (op < 4) begin
        wd  = 16'($urandom);
        u_n = 1'($urandom);
        l_n = 1'($urandom);
        nw  = model[idx];
        if (!u_n) nw[15:8] = wd[15:8];
        if (!l_n) nw[7:0] = wd[7:0];
        model[idx] = nw;
        do_write(0, 23'(idx), u_n, l_n, wd, 2, $urandom_range(2), 1'($urandom));
      end else begin
        do_read(0, 23'(idx), model[idx], 2, 1'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_sram_responder.md
Name: bus_sram_responder

Overview:
- Bus-side responder (slave) for the V68k asynchronous bus: decodes A/AS/UDS/LDS/RW, services reads and writes against an internal word-wide SRAM, and answers with DTACK, or with BERR when the address misses.
- Sits on the shared A/D bus opposite the CPU; it is the memory the CPU's FETCH/WAIT_FOR_INSTRUCTION sequence talks to.
- Wait states are programmable so slow memory can be modelled.

Parameters:
- ADDR_BITS, 10, word-address bits of internal SRAM (2^ADDR_BITS 16-bit words).
- BASE, 24'h000000, byte base address of the decoded window; aligned to 2^(ADDR_BITS+1).
- WAIT_STATES, 1, extra CLK cycles inserted before DTACK (0..15).

Ports:
- CLK  input  1  system clock; all state changes on posedge.
- RESET  input  1  asynchronous, active-high reset.
- A  input  23 [23:1]  word address from CPU.
- AS  input  1  address strobe, active-low.
- UDS  input  1  upper data strobe (D[15:8]), active-low.
- LDS  input  1  lower data strobe (D[7:0]), active-low.
- RW  input  1  1 = read, 0 = write.
- D  inout  16  data bus; driven only while acknowledging a read, otherwise high-Z.
- DTACK  output  1  data acknowledge, active-high (the CPU latches D when DTACK is 1).
- BERR  output  1  bus error, active-high; address outside the window.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, DTACK=0, BERR=0, D released (high-Z), wait counter=0. SRAM contents are not cleared.
- Hit: A[23:ADDR_BITS+1] == BASE[23:ADDR_BITS+1]. Word index = A[ADDR_BITS:1].
- States: IDLE, WAIT, ACK, ERR.
- IDLE:
  - AS sampled 0: latch A, UDS, LDS and RW.
  - Hit: load counter=WAIT_STATES, go to WAIT.
  - Miss: go to ERR.
- WAIT:
  - AS sampled 1: abort, return to IDLE; no write, no DTACK.
  - Counter != 0: decrement.
  - Counter == 0: go to ACK and set DTACK=1 on that edge.
    - Read: drive D with mem[index] (full word, regardless of strobes).
    - Write: sample D; if UDS=0 write D[15:8] to the upper byte; if LDS=0 write D[7:0] to the lower byte.
- Latency: the edge that samples AS low is edge N; DTACK is high after edge N+WAIT_STATES+1.
- ACK:
  - DTACK held at 1 and read data held on D until AS is sampled 1.
  - Then DTACK=0, D released, go to IDLE on that same edge.
  - Exactly one write per cycle, even if ACK lasts several cycles.
- ERR: BERR=1 from the edge after capture until AS is sampled 1; then BERR=0 and go to IDLE. DTACK stays 0.
- Null cycle (AS=0, UDS=LDS=1): acknowledged normally; read drives D; write modifies nothing.
- Strobe/address changes after capture are ignored until the cycle ends.
- Back-to-back cycles: AS must be sampled 1 at least once (the cycle-ending edge) before a new capture. The earliest new capture is the edge after the return to IDLE.
- Exclusivity: DTACK and BERR are never 1 simultaneously. D is never driven during a write or in IDLE/WAIT/ERR.

Test Plan:
- Reset, then write cycle, WAIT_STATES=1: A=23'h000010, UDS=LDS=0, RW=0, D=16'hBEEF, AS=0 -> DTACK=1 after edge N+2; D not driven; AS=1 -> DTACK=0 the next edge; mem[16]=16'hBEEF.
- Read back the same address, RW=1 -> D=16'hBEEF with DTACK=1 after N+2; D high-Z after AS deasserts.
- Byte lanes: write 16'h1234 with LDS=1 (UDS only) over 16'hBEEF -> reads back 16'h12EF; then LDS-only write of 16'hAA55 -> reads back 16'h1255.
- Miss: A=23'h400000, AS=0 -> BERR=1 after edge N+1, DTACK stays 0, D high-Z; AS=1 -> BERR=0; mem unchanged.
- Abort plus async reset: with WAIT_STATES=3, raise AS during WAIT -> no DTACK, no write. Next, assert RESET mid-ACK -> DTACK=0 and D high-Z immediately without a clock edge; earlier data still readable after reset.
- WAIT_STATES=0 back-to-back reads of two addresses -> DTACK after N+1 for each; two cycles never overlap; instruction fetch through the V68k CPU returns the stored opcode 16'h4E71 (NOP).
